// File: rtl/prng_mux_gen_pkg.sv
// Shared LFSR helpers for the pair-mux PRNG: XNOR step function and default tap masks.
package prng_mux_gen_pkg;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // One XNOR shift on the low `width` bits; bits above width come back as zero.
  function automatic logic [31:0] lfsr_xnor_step(input logic [31:0] state,
                                                 input logic [31:0] taps,
                                                 input int unsigned width);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    fb   = ~(^(state & taps & mask));
    return {state[30:0], fb} & mask;
  endfunction

  function automatic logic [31:0] lfsr_default_taps(input int unsigned width);
    case (width)
      8:       return {24'd0, TAPS_W8};
      16:      return {16'd0, TAPS_W16};
      default: return TAPS_W32;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_xnor.sv
// XNOR Fibonacci LFSR with seed load; the all-ones lock-up state is never kept.
module lfsr_xnor
  import prng_mux_gen_pkg::*;
#(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  TAPS = W'(lfsr_default_taps(W))
) (
  input  logic         CLK,
  input  logic         EN,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] ALL_ONES = '1;

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  // Under XNOR feedback all-ones maps to itself, so it is replaced by zero on load or step.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == ALL_ONES) ? '0 : load_val;
    end else if (step) begin
      state_d = (state_q == ALL_ONES) ? '0 : W'(lfsr_xnor_step(32'(state_q), 32'(TAPS), W));
    end
  end

  always_ff @(posedge CLK or negedge EN) begin
    if (!EN) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/prng_mux_gen.sv
// Pair-mux PRNG: data LFSR stepped on divided ticks, free-running select LFSR picks one bit per pair,
// one-deep valid/ready output with sticky overrun.
module prng_mux_gen
  import prng_mux_gen_pkg::*;
#(
  parameter int unsigned         OUT_W     = 8,
  parameter logic [2*OUT_W-1:0]  DATA_TAPS = TAPS_W16,
  parameter logic [OUT_W-1:0]    SEL_TAPS  = TAPS_W8,
  parameter int unsigned         TICK_DIV  = 10_000_000
) (
  input  logic                 CLK,
  input  logic                 EN,
  input  logic                 run,
  input  logic                 seed_load,
  input  logic [2*OUT_W-1:0]   seed_data,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic                 tick_tgl
);

  localparam int unsigned      DATA_W   = 2 * OUT_W;
  localparam int unsigned      CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic              pend_q, pend_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              tick_tgl_q, tick_tgl_d;

  logic              tick;
  logic              accept;
  logic [DATA_W-1:0] data_state;
  logic [OUT_W-1:0]  sel_state;
  logic [OUT_W-1:0]  cand;

  assign tick   = run && (div_cnt_q == DIV_LAST);
  assign accept = out_valid_q && out_ready;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (run) begin
      div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
    end
  end

  lfsr_xnor #(
    .W    (DATA_W),
    .TAPS (DATA_TAPS)
  ) u_data (
    .CLK      (CLK),
    .EN       (EN),
    .step     (tick),
    .load     (seed_load),
    .load_val (seed_data),
    .state    (data_state)
  );

  lfsr_xnor #(
    .W    (OUT_W),
    .TAPS (SEL_TAPS)
  ) u_sel (
    .CLK      (CLK),
    .EN       (EN),
    .step     (1'b1),
    .load     (1'b0),
    .load_val ('0),
    .state    (sel_state)
  );

  for (genvar i = 0; i < OUT_W; i++) begin : g_pair_mux
    assign cand[i] = sel_state[i] ? data_state[2*i+1] : data_state[2*i];
  end

  // Capture runs one edge after the tick so it sees the freshly stepped data LFSR.
  always_comb begin
    pend_d      = tick;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    tick_tgl_d  = tick_tgl_q ^ tick;
    if (pend_q) begin
      if (!out_valid_q || accept) begin
        out_data_d  = cand;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge EN) begin
    if (!EN) begin
      div_cnt_q   <= '0;
      pend_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      tick_tgl_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      pend_q      <= pend_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      tick_tgl_q  <= tick_tgl_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign tick_tgl  = tick_tgl_q;

endmodule

// File: tb/tb_prng_mux_gen.sv
// Bench for prng_mux_gen (TICK_DIV=4, default taps): cycle reference model plus directed and random stimulus.
module tb_prng_mux_gen;

  localparam int          TD = 4;
  localparam logic [15:0] DT = 16'hD008;
  localparam logic [7:0]  ST = 8'hB8;

  logic        CLK       = 1'b0;
  logic        EN        = 1'b1;
  logic        run       = 1'b0;
  logic        seed_load = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] seed_data = 16'h0000;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        overrun;
  logic        tick_tgl;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  prng_mux_gen #(
    .OUT_W    (8),
    .TICK_DIV (TD)
  ) dut (
    .CLK       (CLK),
    .EN        (EN),
    .run       (run),
    .seed_load (seed_load),
    .seed_data (seed_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .tick_tgl  (tick_tgl)
  );

  // reference model state
  int          m_div   = 0;
  logic [15:0] m_data  = 16'h0;
  logic [7:0]  m_sel   = 8'h0;
  logic [7:0]  m_out   = 8'h0;
  logic        m_pend  = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_tgl   = 1'b0;
  logic        model_tick;
  logic        m_acc;

  assign model_tick = run && (m_div == TD - 1);
  assign m_acc      = m_valid && out_ready;

  function automatic logic [15:0] ref_step16(input logic [15:0] s);
    logic p;
    if (s == 16'hFFFF) return 16'h0000;
    p = 1'b0;
    for (int i = 0; i < 16; i++) if (DT[i]) p = p ^ s[i];
    return {s[14:0], !p};
  endfunction

  function automatic logic [7:0] ref_step8(input logic [7:0] s);
    logic p;
    if (s == 8'hFF) return 8'h00;
    p = 1'b0;
    for (int i = 0; i < 8; i++) if (ST[i]) p = p ^ s[i];
    return {s[6:0], !p};
  endfunction

  function automatic logic [7:0] ref_mux(input logic [15:0] d, input logic [7:0] s);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) c[i] = s[i] ? d[2*i+1] : d[2*i];
    return c;
  endfunction

  always @(posedge CLK or negedge EN) begin
    if (!EN) begin
      m_div   <= 0;
      m_data  <= 16'h0;
      m_sel   <= 8'h0;
      m_out   <= 8'h0;
      m_pend  <= 1'b0;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
      m_tgl   <= 1'b0;
    end else begin
      if (run) m_div <= model_tick ? 0 : m_div + 1;
      if (seed_load)       m_data <= (seed_data == 16'hFFFF) ? 16'h0 : seed_data;
      else if (model_tick) m_data <= ref_step16(m_data);
      m_sel  <= ref_step8(m_sel);
      m_pend <= model_tick;
      m_tgl  <= m_tgl ^ model_tick;
      if (m_pend) begin
        if (!m_valid || m_acc) begin
          m_out   <= ref_mux(m_data, m_sel);
          m_valid <= 1'b1;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_acc) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("cyc_out_data", {24'd0, out_data}, {24'd0, m_out});
    chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("cyc_overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("cyc_tick_tgl", {31'd0, tick_tgl}, {31'd0, m_tgl});
    chk("cyc_data_lfsr", {16'd0, dut.data_state}, {16'd0, m_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_seq [5];
    int          acc_cnt;
    int          wait_n;
    int          edges;
    logic        tgl0;
    exp_seq = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001E};

    // reset
    #1 EN = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_tick_tgl", {31'd0, tick_tgl}, 0);
    @(negedge CLK);
    run = 1'b1;
    EN  = 1'b1;

    // latency, streaming accept, overrun and accept-without-capture
    acc_cnt = 0;
    for (int k = 1; k <= 29; k++) begin
      if (k >= 6 && k <= 20 && out_valid && out_ready) acc_cnt++;
      @(posedge CLK);
      #1;
      if (k % 4 == 0 && k <= 20) begin
        chk("seq_model", {16'd0, m_data}, {16'd0, exp_seq[k/4-1]});
        chk("seq_dut", {16'd0, dut.data_state}, {16'd0, exp_seq[k/4-1]});
      end
      case (k)
        4:  chk("valid_before_latency", {31'd0, out_valid}, 0);
        5:  begin chk("valid_latency", {31'd0, out_valid}, 1); out_ready = 1'b1; end
        20: begin
              chk("overrun_streaming", {31'd0, overrun}, 0);
              chk("accept_count", acc_cnt, 4);
              out_ready = 1'b0;
            end
        24: chk("overrun_before_drop", {31'd0, overrun}, 0);
        25: chk("overrun_after_drop", {31'd0, overrun}, 1);
        26: out_ready = 1'b1;
        27: begin chk("valid_drop_on_accept", {31'd0, out_valid}, 0); out_ready = 1'b0; end
        28: chk("valid_idle", {31'd0, out_valid}, 0);
        29: chk("valid_next_capture", {31'd0, out_valid}, 1);
        default: ;
      endcase
    end

    // seed all-ones, then seed coincident with a tick
    seed_data = 16'hFFFF;
    seed_load = 1'b1;
    @(posedge CLK);
    #1;
    seed_load = 1'b0;
    chk("seed_ones_model", {16'd0, m_data}, 0);
    chk("seed_ones_dut", {16'd0, dut.data_state}, 0);
    wait_n = 0;
    while (m_div != TD - 1 && wait_n < 8) begin
      @(posedge CLK);
      #1;
      wait_n++;
    end
    chk("tick_align_bound", {31'd0, (m_div == TD - 1)}, 1);
    tgl0      = m_tgl;
    seed_data = 16'h1234;
    seed_load = 1'b1;
    @(posedge CLK);
    #1;
    seed_load = 1'b0;
    chk("seed_tick_model", {16'd0, m_data}, 32'h1234);
    chk("seed_tick_dut", {16'd0, dut.data_state}, 32'h1234);
    chk("seed_tick_pend", {31'd0, m_pend}, 1);
    chk("seed_tick_tgl", {31'd0, tick_tgl}, {31'd0, !tgl0});

    // run=0 freeze and resume
    wait_n = 0;
    while (m_div != 1 && wait_n < 8) begin
      @(posedge CLK);
      #1;
      wait_n++;
    end
    run  = 1'b0;
    tgl0 = m_tgl;
    repeat (10) @(posedge CLK);
    #1;
    chk("freeze_tgl", {31'd0, tick_tgl}, {31'd0, tgl0});
    chk("freeze_div_model", m_div, 1);
    chk("freeze_div_dut", {30'd0, dut.div_cnt_q}, 1);
    run   = 1'b1;
    edges = 0;
    while (tick_tgl == tgl0 && edges < 10) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    chk("resume_edges", edges, 3);

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      run       = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      seed_load = ($urandom_range(0, 15) == 0);
      seed_data = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    end
    @(negedge CLK);
    seed_load = 1'b0;
    run       = 1'b1;
    out_ready = 1'b0;

    // async reset while a capture is pending and a sample is held
    wait_n = 0;
    @(posedge CLK);
    #1;
    while (!(m_pend && m_valid) && wait_n < 24) begin
      @(posedge CLK);
      #1;
      wait_n++;
    end
    chk("pend_valid_bound", {31'd0, (m_pend && m_valid)}, 1);
    #2 EN = 1'b0;
    #1;
    chk("async_out_data", {24'd0, out_data}, 0);
    chk("async_out_valid", {31'd0, out_valid}, 0);
    chk("async_overrun", {31'd0, overrun}, 0);
    chk("async_tick_tgl", {31'd0, tick_tgl}, 0);
    @(negedge CLK);
    EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("no_capture_after_reset", {31'd0, out_valid}, 0);
    end

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
